// File: rtl/sample_scan_ctrl.sv
// Sample-grid scan controller: walks a bounding box in raster order, one sample per cycle.
// Optional SAMPLE_SCAN_STATS_EN adds saturating sample/box counters.
module sample_scan_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          box_valid_i,
  input  logic [VERTS*AXIS*SIGFIG-1:0]  tri_i,
  input  logic [2*SIGFIG-1:0]           box_ll_i,
  input  logic [2*SIGFIG-1:0]           box_ur_i,
  input  logic [3:0]                    subsample_i,
  input  logic                          halt_i,
  output logic                          halt_o,
  output logic                          sample_valid_o,
  output logic [2*SIGFIG-1:0]           sample_o,
  output logic [VERTS*AXIS*SIGFIG-1:0]  tri_o,
  output logic                          dbg_state_o
`ifdef SAMPLE_SCAN_STATS_EN
  ,
  output logic [31:0]                   stat_samples_o,
  output logic [15:0]                   stat_boxes_o
`endif
);

  localparam int W = SIGFIG + 1;

  // Handshake: a box transfers on a rising edge where box_valid_i=1 and halt_o=0;
  // a sample is consumed on a rising edge where sample_valid_o=1 and halt_i=0.
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                         r_state;
  state_t                         w_state_nxt;
  logic [SIGFIG-1:0]              r_x, r_y, r_ll_x, r_ur_x, r_ur_y, r_step;
  logic [VERTS*AXIS*SIGFIG-1:0]   r_tri;

  logic [SIGFIG-1:0]  w_in_ll_x, w_in_ll_y, w_in_ur_x, w_in_ur_y, w_step_in;
  logic signed [W-1:0] w_x_inc, w_y_inc, w_ur_x_ext, w_ur_y_ext;
  logic               w_x_over, w_y_over, w_adv, w_done, w_degen, w_accept, w_load;
  int                 w_shift;

  assign w_in_ll_x = box_ll_i[SIGFIG-1:0];
  assign w_in_ll_y = box_ll_i[2*SIGFIG-1:SIGFIG];
  assign w_in_ur_x = box_ur_i[SIGFIG-1:0];
  assign w_in_ur_y = box_ur_i[2*SIGFIG-1:SIGFIG];

  always_comb begin
    w_shift = RADIX;
    case (subsample_i)
      4'b1000: w_shift = RADIX;
      4'b0100: w_shift = RADIX - 1;
      4'b0010: w_shift = RADIX - 2;
      4'b0001: w_shift = RADIX - 3;
      default: w_shift = RADIX;
    endcase
  end
  assign w_step_in = SIGFIG'(1) << w_shift;

  // One extra bit so stepping past the top of the signed range cannot wrap.
  assign w_x_inc    = {r_x[SIGFIG-1], r_x} + {1'b0, r_step};
  assign w_y_inc    = {r_y[SIGFIG-1], r_y} + {1'b0, r_step};
  assign w_ur_x_ext = {r_ur_x[SIGFIG-1], r_ur_x};
  assign w_ur_y_ext = {r_ur_y[SIGFIG-1], r_ur_y};
  assign w_x_over   = w_x_inc > w_ur_x_ext;
  assign w_y_over   = w_y_inc > w_ur_y_ext;

  assign w_adv    = (r_state == SCAN) && !halt_i;
  assign w_done   = w_adv && w_x_over && w_y_over;
  assign w_degen  = ($signed(w_in_ur_x) < $signed(w_in_ll_x)) ||
                    ($signed(w_in_ur_y) < $signed(w_in_ll_y));
  assign halt_o   = (r_state == SCAN) && !w_done;
  assign w_accept = box_valid_i && !halt_o;
  assign w_load   = w_accept && !w_degen;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_load) w_state_nxt = SCAN;
      SCAN: if (w_done) w_state_nxt = w_load ? SCAN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_ll_x <= '0;
      r_ur_x <= '0;
      r_ur_y <= '0;
      r_step <= '0;
      r_tri  <= '0;
    end else if (w_load) begin
      r_x    <= w_in_ll_x;
      r_y    <= w_in_ll_y;
      r_ll_x <= w_in_ll_x;
      r_ur_x <= w_in_ur_x;
      r_ur_y <= w_in_ur_y;
      r_step <= w_step_in;
      r_tri  <= tri_i;
    end else if (w_adv && !w_x_over) begin
      r_x <= w_x_inc[SIGFIG-1:0];
    end else if (w_adv && !w_y_over) begin
      r_x <= r_ll_x;
      r_y <= w_y_inc[SIGFIG-1:0];
    end
  end

  assign sample_valid_o = (r_state == SCAN);
  assign sample_o       = {r_y, r_x};
  assign tri_o          = r_tri;
  assign dbg_state_o    = r_state;

`ifdef SAMPLE_SCAN_STATS_EN
  logic [31:0] r_stat_samples;
  logic [15:0] r_stat_boxes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_samples <= '0;
      r_stat_boxes   <= '0;
    end else begin
      if (w_adv && (r_stat_samples != '1)) r_stat_samples <= r_stat_samples + 32'd1;
      if (w_done && (r_stat_boxes != '1))  r_stat_boxes   <= r_stat_boxes + 16'd1;
    end
  end

  assign stat_samples_o = r_stat_samples;
  assign stat_boxes_o   = r_stat_boxes;
`endif

endmodule

// File: tb/tb_sample_scan_ctrl.sv
// Directed bench for sample_scan_ctrl: raster order, stalls, back-to-back boxes,
// degenerate boxes, reset, step sizes and (with SAMPLE_SCAN_STATS_EN) the counters.
module tb_sample_scan_ctrl;
  localparam int SIGFIG = 24;
  localparam int TW     = 3 * 3 * SIGFIG;

  logic              clk = 1'b0;
  logic              rst;
  logic              box_valid_i;
  logic [TW-1:0]     tri_i;
  logic [47:0]       box_ll_i, box_ur_i;
  logic [3:0]        subsample_i;
  logic              halt_i;
  logic              halt_o, sample_valid_o, dbg_state_o;
  logic [47:0]       sample_o;
  logic [TW-1:0]     tri_o;
`ifdef SAMPLE_SCAN_STATS_EN
  logic [31:0]       stat_samples_o;
  logic [15:0]       stat_boxes_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [TW-1:0] tri_a, tri_b;

  sample_scan_ctrl dut (
    .clk(clk), .rst(rst), .box_valid_i(box_valid_i), .tri_i(tri_i),
    .box_ll_i(box_ll_i), .box_ur_i(box_ur_i), .subsample_i(subsample_i),
    .halt_i(halt_i), .halt_o(halt_o), .sample_valid_o(sample_valid_o),
    .sample_o(sample_o), .tri_o(tri_o), .dbg_state_o(dbg_state_o)
`ifdef SAMPLE_SCAN_STATS_EN
    , .stat_samples_o(stat_samples_o), .stat_boxes_o(stat_boxes_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] pack(input int x, input int y);
    return {24'(y), 24'(x)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_box(input logic v, input int llx, input int lly, input int urx,
                           input int ury, input logic [3:0] sub, input logic [TW-1:0] t);
    box_valid_i = v;
    box_ll_i    = pack(llx, lly);
    box_ur_i    = pack(urx, ury);
    subsample_i = sub;
    tri_i       = t;
  endtask

  task automatic test_reset();
    rst = 1'b1; box_valid_i = 1'b0; halt_i = 1'b0;
    drive_box(1'b0, 0, 0, 0, 0, 4'b1000, '1);
    step(); step();
    n_checks++;
    if (sample_valid_o !== 1'b0 || halt_o !== 1'b0 || dbg_state_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: valid=%b halt=%b state=%b expected 0 0 0",
                         sample_valid_o, halt_o, dbg_state_o);
    end
    n_checks++;
    if (sample_o !== 48'd0 || tri_o !== '0) begin
      n_fail++; $display("FAIL reset_data: sample=%h tri=%h expected zero", sample_o, tri_o);
    end
`ifdef SAMPLE_SCAN_STATS_EN
    n_checks++;
    if (stat_samples_o !== 32'd0 || stat_boxes_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_stats: %0d %0d expected 0 0", stat_samples_o, stat_boxes_o);
    end
`endif
    // Reset coinciding with a valid box must drop the box.
    drive_box(1'b1, 0, 0, 2048, 1024, 4'b1000, tri_a);
    step();
    rst = 1'b0; box_valid_i = 1'b0;
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_vs_box: valid=%b expected 0", sample_valid_o);
    end
    step();
  endtask

  task automatic test_basic();
    int ex[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int ey[6] = '{0, 0, 0, 1024, 1024, 1024};
    drive_box(1'b1, 0, 0, 2048, 1024, 4'b1000, tri_a);
    #1;
    n_checks++;
    if (halt_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle_halt: got %b expected 0", halt_o);
    end
    step();
    box_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== pack(ex[i], ey[i])) begin
        n_fail++; $display("FAIL basic_sample%0d: valid=%b sample=%h expected 1 %h",
                           i, sample_valid_o, sample_o, pack(ex[i], ey[i]));
      end
      n_checks++;
      if (halt_o !== (i != 5) || tri_o !== tri_a) begin
        n_fail++; $display("FAIL basic_halt_tri%0d: halt=%b expected %b, tri=%h", i, halt_o,
                           (i != 5), tri_o);
      end
      step();
    end
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b0 || halt_o !== 1'b0) begin
      n_fail++; $display("FAIL basic_end: valid=%b halt=%b expected 0 0", sample_valid_o, halt_o);
    end
  endtask

  task automatic test_halt();
    int ex[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int ey[6] = '{0, 0, 0, 1024, 1024, 1024};
    drive_box(1'b1, 0, 0, 2048, 1024, 4'b1000, tri_b);
    step();
    box_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      for (int h = 0; h < ((i == 1) ? 4 : 1); h++) begin
        halt_i = (i == 1) && (h < 3);
        #1;
        n_checks++;
        if (sample_valid_o !== 1'b1 || sample_o !== pack(ex[i], ey[i]) || tri_o !== tri_b) begin
          n_fail++; $display("FAIL halt_sample%0d_%0d: valid=%b sample=%h expected %h",
                             i, h, sample_valid_o, sample_o, pack(ex[i], ey[i]));
        end
        step();
      end
    end
    halt_i = 1'b0;
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL halt_end: valid=%b expected 0", sample_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int ex[6] = '{0, 1024, 2048, 0, 1024, 2048};
    int ey[6] = '{0, 0, 0, 1024, 1024, 1024};
    drive_box(1'b1, 0, 0, 2048, 1024, 4'b1000, tri_a);
    step();
    drive_box(1'b1, 4096, 4096, 4096, 4096, 4'b1000, tri_b);
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== pack(ex[i], ey[i]) || tri_o !== tri_a) begin
        n_fail++; $display("FAIL b2b_first%0d: valid=%b sample=%h expected %h",
                           i, sample_valid_o, sample_o, pack(ex[i], ey[i]));
      end
      step();
    end
    box_valid_i = 1'b0;
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b1 || sample_o !== pack(4096, 4096) || tri_o !== tri_b) begin
      n_fail++; $display("FAIL b2b_second: valid=%b sample=%h expected 1 %h",
                         sample_valid_o, sample_o, pack(4096, 4096));
    end
    n_checks++;
    if (halt_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_halt: got %b expected 0", halt_o);
    end
    step();
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: valid=%b expected 0", sample_valid_o);
    end
  endtask

  task automatic test_degenerate();
`ifdef SAMPLE_SCAN_STATS_EN
    logic [15:0] b0 = stat_boxes_o;
    logic [31:0] s0 = stat_samples_o;
`endif
    for (int c = 0; c < 2; c++) begin
      if (c == 0) drive_box(1'b1, 2048, 0, 1024, 0, 4'b1000, tri_a);
      else        drive_box(1'b1, 0, 1024, 0, 0, 4'b1000, tri_a);
      step();
      box_valid_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        #1;
        n_checks++;
        if (sample_valid_o !== 1'b0 || halt_o !== 1'b0) begin
          n_fail++; $display("FAIL degen%0d_%0d: valid=%b halt=%b expected 0 0",
                             c, k, sample_valid_o, halt_o);
        end
        step();
      end
    end
`ifdef SAMPLE_SCAN_STATS_EN
    n_checks++;
    if (stat_boxes_o !== b0 || stat_samples_o !== s0) begin
      n_fail++; $display("FAIL degen_stats: boxes=%0d samples=%0d expected %0d %0d",
                         stat_boxes_o, stat_samples_o, b0, s0);
    end
`endif
  endtask

  task automatic test_reset_midscan();
    drive_box(1'b1, 0, 0, 2048, 1024, 4'b1000, tri_a);
    step();
    box_valid_i = 1'b0;
    step(); step();
    #1;
    n_checks++;
    if (sample_o !== pack(2048, 0) || sample_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL midrst_third: sample=%h expected %h", sample_o, pack(2048, 0));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b0 || sample_o !== 48'd0 || tri_o !== '0) begin
      n_fail++; $display("FAIL midrst_after: valid=%b sample=%h expected 0 0",
                         sample_valid_o, sample_o);
    end
    drive_box(1'b1, 3072, 2048, 4096, 2048, 4'b1000, tri_b);
    step();
    box_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (sample_valid_o !== 1'b1 || sample_o !== pack(3072 + 1024 * i, 2048)) begin
        n_fail++; $display("FAIL midrst_new%0d: sample=%h expected %h", i, sample_o,
                           pack(3072 + 1024 * i, 2048));
      end
      step();
    end
    #1;
    n_checks++;
    if (sample_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_end: valid=%b expected 0", sample_valid_o);
    end
  endtask

  // Cases: subsample code, expected step, box ll/ur; the final two probe signed
  // coordinates and the top of the positive range.
  task automatic test_subsample();
    logic [3:0] sub_t[6] = '{4'b0100, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1000};
    int st_t[6]  = '{512, 128, 256, 1024, 1024, 1024};
    int llx_t[6] = '{0, 0, 0, 0, -1024, 8387584};
    int lly_t[6] = '{0, 0, 0, 0, -1024, 0};
    int urx_t[6] = '{1024, 256, 512, 1024, 0, 8387584};
    int ury_t[6] = '{1024, 0, 0, 0, -1024, 1024};
`ifdef SAMPLE_SCAN_STATS_EN
    logic [15:0] b0 = stat_boxes_o;
    logic [31:0] s0 = stat_samples_o;
`endif
    for (int c = 0; c < 6; c++) begin
      int n = 0;
      drive_box(1'b1, llx_t[c], lly_t[c], urx_t[c], ury_t[c], sub_t[c], tri_a);
      step();
      box_valid_i = 1'b0;
      for (int yy = lly_t[c]; yy <= ury_t[c]; yy += st_t[c]) begin
        for (int xx = llx_t[c]; xx <= urx_t[c]; xx += st_t[c]) begin
          #1;
          n_checks++;
          if (sample_valid_o !== 1'b1 || sample_o !== pack(xx, yy)) begin
            n_fail++; $display("FAIL sub%0d_s%0d: valid=%b sample=%h expected %h",
                               c, n, sample_valid_o, sample_o, pack(xx, yy));
          end
          n++;
          step();
        end
      end
      #1;
      n_checks++;
      if (sample_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL sub%0d_end: valid=%b expected 0 after %0d samples",
                           c, sample_valid_o, n);
      end
`ifdef SAMPLE_SCAN_STATS_EN
      if (c == 0) begin
        n_checks++;
        if (stat_samples_o !== s0 + 32'd9 || stat_boxes_o !== b0 + 16'd1) begin
          n_fail++; $display("FAIL sub_stats: samples=%0d boxes=%0d expected %0d %0d",
                             stat_samples_o, stat_boxes_o, s0 + 32'd9, b0 + 16'd1);
        end
      end
`endif
    end
  endtask

  initial begin
    tri_a = {9{24'h123456}};
    tri_b = {9{24'hABCDEF}};
    test_reset();
    test_basic();
    test_halt();
    test_back_to_back();
    test_degenerate();
    test_reset_midscan();
    test_subsample();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sample_scan_ctrl.md
SAMPLE_SCAN_CTRL -- requirements
Module: sample_scan_ctrl

Interface
REQ-001 Parameter SIGFIG, default 24: bits per coordinate.
REQ-002 Parameter RADIX, default 10: fraction bits per coordinate; one pixel = 1<<RADIX.
REQ-003 Parameter VERTS, default 3: vertices per triangle.
REQ-004 Parameter AXIS, default 3: axes per vertex.
REQ-005 Port clk  input  1  single clock; all logic on rising edge.
REQ-006 Port rst  input  1  synchronous, active-high reset.
REQ-007 Port box_valid_i  input  1  upstream box/triangle valid.
REQ-008 Port tri_i  input  VERTS*AXIS*SIGFIG  triangle vertices.
REQ-009 Port box_ll_i  input  2*SIGFIG  lower-left {y,x}, pre-snapped to the sample grid.
REQ-010 Port box_ur_i  input  2*SIGFIG  upper-right {y,x}, pre-snapped to the sample grid.
REQ-011 Port subsample_i  input  4  one-hot step: 1000=1 px, 0100=1/2, 0010=1/4, 0001=1/8.
REQ-012 Port halt_i  input  1  downstream stall.
REQ-013 Port halt_o  output  1  upstream stall; box is accepted only when box_valid_i=1 and halt_o=0.
REQ-014 Port sample_valid_o  output  1  sample valid.
REQ-015 Port sample_o  output  2*SIGFIG  sample {y,x}.
REQ-016 Port tri_o  output  VERTS*AXIS*SIGFIG  triangle latched for the current box.

Function
REQ-017 Two states: IDLE and SCAN. IDLE: halt_o=0 and sample_valid_o=0. SCAN: sample_valid_o=1.
REQ-018 Step is 1<<(RADIX-k), where k=0,1,2,3 for subsample_i=1000,0100,0010,0001; any non-one-hot value uses k=0. Step is latched at acceptance.
REQ-019 Acceptance at clock edge N latches tri_i, box_ll_i, box_ur_i and the step, sets the sample to box_ll_i and enters SCAN; first sample_valid_o=1 in cycle N+1.
REQ-020 Box with ur.x<ll.x or ur.y<ll.y (signed compare): accepted, discarded, no samples, stays IDLE.
REQ-021 SCAN with halt_i=1: sample_o, tri_o and sample_valid_o hold unchanged.
REQ-022 SCAN with halt_i=0, raster order: x+=step; if new x>ur.x then x=ll.x and y+=step; if new y>ur.y the box is complete.
REQ-023 Increment/compare is SIGFIG+1 bits wide; no wrap-around at the top of range.
REQ-024 Last sample (x==ur.x, y==ur.y) with halt_i=0: halt_o=0 combinationally that cycle. If box_valid_i=1, the new box loads with no bubble. Otherwise go to IDLE.
REQ-025 halt_o=1 in SCAN except as in REQ-024.
REQ-026 sample_o and tri_o are don't-care when sample_valid_o=0, but hold their last value.

Reset
REQ-027 rst=1 at any edge: state=IDLE, sample_valid_o=0, sample_o=0, tri_o=0, stats=0. Takes effect in the next cycle, including mid-scan.
REQ-028 Reset in the same cycle as box_valid_i: reset wins and the box is not accepted.

Configuration
REQ-029 With macro SAMPLE_SCAN_STATS_EN defined, add these outputs:
- stat_samples_o (32 bits): +1 per sample with sample_valid_o=1 and halt_i=0.
- stat_boxes_o (16 bits): +1 per completed non-degenerate box.
- Both saturate at all-ones.
REQ-030 Without SAMPLE_SCAN_STATS_EN, the stat ports and counters are absent; all other behaviour is identical.

Verification
REQ-031 ll=(0,0), ur=(2048,1024), step 1 px, halt_i=0 -> exactly 6 samples on consecutive cycles: (0,0), (1024,0), (2048,0), (0,1024), (1024,1024), (2048,1024), then IDLE.
REQ-032 Same box, halt_i=1 for 3 cycles while sample (1024,0) is presented -> (1024,0) held 4 cycles with sample_valid_o=1; the sequence is then unchanged.
REQ-033 Two valid boxes back-to-back, second ll=(4096,4096), ur=(4096,4096) -> first sample of the second box in the cycle after the last sample of the first box; no invalid cycle between them.
REQ-034 ll=(2048,0), ur=(1024,0) -> zero samples; halt_o stays 0; stat_boxes_o unchanged.
REQ-035 rst asserted during the 3rd sample of the REQ-031 box -> sample_valid_o=0 next cycle; a new box then scans from its own ll.
REQ-036 With SAMPLE_SCAN_STATS_EN, ll=(0,0), ur=(1024,1024), subsample 0100 -> 9 samples with step 512; stat_samples_o=9, stat_boxes_o=1.
